// File: rtl/led_seq_pkg.sv
// Shared encodings for the AHB LED sequencer: mode values, register offsets,
// sequencer states and the mode-to-entry-state mapping.
package led_seq_pkg;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_ROT_L  = 2'd2;
   localparam logic [1:0] MODE_ROT_R  = 2'd3;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_PATTERN = 2'd1;
   localparam logic [1:0] REG_PERIOD  = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_STATIC,
      ST_BLINK_ON,
      ST_BLINK_OFF,
      ST_ROTATE
   } led_state_t;

   // State the sequencer (re)starts in after any configuration write.
   function automatic led_state_t entry_state(input logic en, input logic [1:0] mode);
      led_state_t st;
      if (!en)
         st = ST_OFF;
      else if (mode == MODE_STATIC)
         st = ST_STATIC;
      else if (mode == MODE_BLINK)
         st = ST_BLINK_ON;
      else
         st = ST_ROTATE;
      return st;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: one-cycle tick every PERIOD+1 enabled cycles,
// restarted from zero by clr (clr also suppresses a coincident tick).
module led_tick_gen #(
   parameter int PRESC_W = 24
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] period,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;
   logic               at_end;

   assign at_end = (cnt == period);
   assign tick   = en & ~clr & at_end;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= at_end ? '0 : cnt + PRESC_W'(1);
   end

endmodule

// File: rtl/ahb_led_sequencer.sv
// AHB-Lite LED slave: register file for mode/pattern/period, plus an autonomous
// sequencer that drives static, blink or rotating patterns on the 16 LEDs.
module ahb_led_sequencer
   import led_seq_pkg::*;
#(
   parameter int                 PRESC_W    = 24,
   parameter logic [PRESC_W-1:0] PERIOD_RST = 24'd5000000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [15:0] LED_OUT
);

   logic               d_valid, d_write;
   logic [1:0]         d_addr;
   logic               wr_en, reload, tick, tick_en;
   logic [2:0]         ctrl, ctrl_nxt;
   logic [15:0]        pattern, pattern_nxt;
   logic [PRESC_W-1:0] period, period_nxt;
   logic [15:0]        step, led, led_nxt;
   led_state_t         state, state_nxt;
   logic               unused_bus_bits;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign LED_OUT   = led;

   assign unused_bus_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

   // Address phase is sampled only when the bus advances.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         d_valid <= 1'b0;
         d_write <= 1'b0;
         d_addr  <= 2'd0;
      end else if (HREADY) begin
         d_valid <= HSEL & HTRANS[1];
         d_write <= HWRITE;
         d_addr  <= HADDR[3:2];
      end
   end

   assign wr_en  = d_valid & d_write & HREADY;
   assign reload = wr_en & (d_addr != REG_STATUS);

   // Next register values feed the sequencer directly so the LEDs follow a
   // write in the very next cycle.
   always_comb begin
      ctrl_nxt    = ctrl;
      pattern_nxt = pattern;
      period_nxt  = period;
      if (wr_en) begin
         case (d_addr)
            REG_CTRL:    ctrl_nxt    = HWDATA[2:0];
            REG_PATTERN: pattern_nxt = HWDATA[15:0];
            REG_PERIOD:  period_nxt  = HWDATA[PRESC_W-1:0];
            default:     ;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ctrl    <= 3'd0;
         pattern <= 16'd0;
         period  <= PERIOD_RST;
      end else begin
         ctrl    <= ctrl_nxt;
         pattern <= pattern_nxt;
         period  <= period_nxt;
      end
   end

   assign tick_en = ctrl[2] & (ctrl[1:0] != MODE_STATIC);

   led_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .en      (tick_en),
      .clr     (reload),
      .period  (period),
      .tick    (tick)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         step <= 16'd0;
      else if (reload)
         step <= 16'd0;
      else if (tick)
         step <= step + 16'd1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_OFF;
         led   <= 16'd0;
      end else begin
         state <= state_nxt;
         led   <= led_nxt;
      end
   end

   // A configuration write takes priority over a tick landing in the same cycle.
   always_comb begin
      state_nxt = state;
      led_nxt   = led;
      if (reload) begin
         state_nxt = entry_state(ctrl_nxt[2], ctrl_nxt[1:0]);
         led_nxt   = (state_nxt == ST_OFF) ? 16'd0 : pattern_nxt;
      end else if (tick) begin
         case (state)
            ST_BLINK_ON: begin
               state_nxt = ST_BLINK_OFF;
               led_nxt   = 16'd0;
            end
            ST_BLINK_OFF: begin
               state_nxt = ST_BLINK_ON;
               led_nxt   = pattern;
            end
            ST_ROTATE: begin
               if (ctrl[1:0] == MODE_ROT_R)
                  led_nxt = {led[0], led[15:1]};
               else
                  led_nxt = {led[14:0], led[15]};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      HRDATA = 32'd0;
      if (d_valid && !d_write) begin
         case (d_addr)
            REG_CTRL:    HRDATA = {29'd0, ctrl};
            REG_PATTERN: HRDATA = {16'd0, pattern};
            REG_PERIOD:  HRDATA = 32'(period);
            default:     HRDATA = {step, led};
         endcase
      end
   end

endmodule
